// File: rtl/ifm_chunk_loader.sv
// ifm_chunk_loader
// Front end of the IFM ping-pong chunk buffer. Each accepted bus beat is
// zero-compressed into a sparsemap plus nonzero bytes packed toward lane 0
// and written to the bank selected by wr_sel_o. Each bank's fill state is
// tracked, and the producer is stalled while the target bank is still FULL.
//
// Optional feature: define IFM_LOADER_COMPRESS_EN to enable zero
// compression. Without it the beat passes through unchanged, with an
// all-ones sparsemap. Timing and the bank handshake are the same in both
// builds.
//
// Ports:
//   clk_i, rst_i        clock, synchronous active-high reset
//   in_data_i           dense beat, lane i = in_data_i[8*i +: 8]
//   in_valid_i/ready_o  producer handshake
//   wr_sparsemap_o      bit i set when lane i is nonzero
//   wr_nonzero_data_o   packed nonzero bytes, unused lanes zero
//   wr_valid_o          one-cycle write strobe per beat
//   wr_count_o          beat index within the chunk
//   wr_sel_o            bank being written
//   rd_sel_o            bank the consumer reads
//   chunk_rdy_o         bank rd_sel_o holds a complete chunk
//   rd_release_i        consumer done with bank rd_sel_o (one-cycle pulse)
//
// Bank state table:
//   BANK_EMPTY   | no data, may be written
//   BANK_FILLING | at least one beat written, chunk incomplete
//   BANK_FULL    | complete chunk, owned by the consumer until released
module ifm_chunk_loader #(
  parameter int BUS_SIZE = 8,
  parameter int MEM_SIZE = 32
) (
  input  logic                                   clk_i,
  input  logic                                   rst_i,
  input  logic [BUS_SIZE*8-1:0]                  in_data_i,
  input  logic                                   in_valid_i,
  output logic                                   in_ready_o,
  output logic [BUS_SIZE-1:0]                    wr_sparsemap_o,
  output logic [BUS_SIZE*8-1:0]                  wr_nonzero_data_o,
  output logic                                   wr_valid_o,
  output logic [$clog2(MEM_SIZE/BUS_SIZE)-1:0]   wr_count_o,
  output logic                                   wr_sel_o,
  output logic                                   rd_sel_o,
  output logic                                   chunk_rdy_o,
  input  logic                                   rd_release_i
);

  localparam int WR_CYC_NUM = MEM_SIZE / BUS_SIZE;
  localparam int CW = $clog2(WR_CYC_NUM);
  localparam logic [CW-1:0] LAST_BEAT = CW'(WR_CYC_NUM - 1);

  typedef enum logic [1:0] {
    BANK_EMPTY   = 2'd0,
    BANK_FILLING = 2'd1,
    BANK_FULL    = 2'd2
  } bank_state_t;

  bank_state_t bank_q [2];
  bank_state_t bank_d [2];

  // Write position for the next accepted beat. The wr_count_o/wr_sel_o
  // outputs are delayed copies that travel with the registered data.
  logic [CW-1:0] cnt_q;
  logic          sel_q;

  logic                  accept;
  logic                  full_set;
  logic                  rel_ok;
  logic [BUS_SIZE-1:0]   map_d;
  logic [BUS_SIZE*8-1:0] pack_d;

  assign in_ready_o  = !rst_i && (bank_q[sel_q] != BANK_FULL);
  assign accept      = in_valid_i && in_ready_o;
  assign chunk_rdy_o = (bank_q[rd_sel_o] == BANK_FULL);
  assign rel_ok      = rd_release_i && chunk_rdy_o;
  // Bank goes FULL on the edge that ends the last beat's strobe, so the
  // buffer has captured that beat before the consumer is told.
  assign full_set    = wr_valid_o && (wr_count_o == LAST_BEAT);

`ifdef IFM_LOADER_COMPRESS_EN
  always_comb begin : compress
    int k;
    k      = 0;
    map_d  = '0;
    pack_d = '0;
    for (int i = 0; i < BUS_SIZE; i++) begin
      if (in_data_i[i*8 +: 8] != 8'h00) begin
        map_d[i]          = 1'b1;
        pack_d[k*8 +: 8]  = in_data_i[i*8 +: 8];
        k                 = k + 1;
      end
    end
  end
`else
  always_comb begin
    map_d  = '1;
    pack_d = in_data_i;
  end
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_valid_o        <= 1'b0;
      wr_sparsemap_o    <= '0;
      wr_nonzero_data_o <= '0;
      wr_count_o        <= '0;
      wr_sel_o          <= 1'b0;
      rd_sel_o          <= 1'b0;
      cnt_q             <= '0;
      sel_q             <= 1'b0;
    end else begin
      wr_valid_o <= accept;
      if (accept) begin
        wr_sparsemap_o    <= map_d;
        wr_nonzero_data_o <= pack_d;
        wr_count_o        <= cnt_q;
        wr_sel_o          <= sel_q;
        if (cnt_q == LAST_BEAT) begin
          cnt_q <= '0;
          sel_q <= ~sel_q;
        end else begin
          cnt_q <= cnt_q + 1'b1;
        end
      end
      if (rel_ok) begin
        rd_sel_o <= ~rd_sel_o;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      bank_q[0] <= BANK_EMPTY;
      bank_q[1] <= BANK_EMPTY;
    end else begin
      bank_q[0] <= bank_d[0];
      bank_q[1] <= bank_d[1];
    end
  end

  // A FULL-set and a release always target different banks, so both apply.
  always_comb begin
    bank_d[0] = bank_q[0];
    bank_d[1] = bank_q[1];
    for (int b = 0; b < 2; b++) begin
      if (accept && (sel_q == 1'(b)) && (bank_q[b] == BANK_EMPTY)) begin
        bank_d[b] = BANK_FILLING;
      end
      if (full_set && (wr_sel_o == 1'(b))) begin
        bank_d[b] = BANK_FULL;
      end
      if (rel_ok && (rd_sel_o == 1'(b))) begin
        bank_d[b] = BANK_EMPTY;
      end
    end
  end

endmodule

// File: tb/tb_ifm_chunk_loader.sv
// Directed bench for ifm_chunk_loader (BUS_SIZE 8, MEM_SIZE 32, 4 beats/chunk).
// Expected values follow the build: compression when IFM_LOADER_COMPRESS_EN
// is defined, pass-through otherwise.
module tb_ifm_chunk_loader;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic [63:0] in_data_i;
  logic        in_valid_i;
  logic        in_ready_o;
  logic [7:0]  wr_sparsemap_o;
  logic [63:0] wr_nonzero_data_o;
  logic        wr_valid_o;
  logic [1:0]  wr_count_o;
  logic        wr_sel_o;
  logic        rd_sel_o;
  logic        chunk_rdy_o;
  logic        rd_release_i;

  int checks = 0;
  int errors = 0;

  localparam logic [63:0] BEAT_A = 64'h4400_0033_2200_1100;
  localparam logic [63:0] BEAT_F = 64'h0102_0304_0506_0708;
`ifdef IFM_LOADER_COMPRESS_EN
  localparam logic [7:0]  EXP_MAP_A = 8'b1001_1010;
  localparam logic [63:0] EXP_DAT_A = 64'h0000_0000_4433_2211;
  localparam logic [7:0]  EXP_MAP_Z = 8'h00;
`else
  localparam logic [7:0]  EXP_MAP_A = 8'hFF;
  localparam logic [63:0] EXP_DAT_A = BEAT_A;
  localparam logic [7:0]  EXP_MAP_Z = 8'hFF;
`endif

  ifm_chunk_loader #(.BUS_SIZE(8), .MEM_SIZE(32)) dut (
    .clk_i(clk_i),
    .rst_i(rst_i),
    .in_data_i(in_data_i),
    .in_valid_i(in_valid_i),
    .in_ready_o(in_ready_o),
    .wr_sparsemap_o(wr_sparsemap_o),
    .wr_nonzero_data_o(wr_nonzero_data_o),
    .wr_valid_o(wr_valid_o),
    .wr_count_o(wr_count_o),
    .wr_sel_o(wr_sel_o),
    .rd_sel_o(rd_sel_o),
    .chunk_rdy_o(chunk_rdy_o),
    .rd_release_i(rd_release_i)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_ready"}, 64'(in_ready_o), 64'd0);
    chk({tag, "_wr_valid"}, 64'(wr_valid_o), 64'd0);
    chk({tag, "_wr_count"}, 64'(wr_count_o), 64'd0);
    chk({tag, "_wr_sel"}, 64'(wr_sel_o), 64'd0);
    chk({tag, "_rd_sel"}, 64'(rd_sel_o), 64'd0);
    chk({tag, "_chunk_rdy"}, 64'(chunk_rdy_o), 64'd0);
    chk({tag, "_map"}, 64'(wr_sparsemap_o), 64'd0);
    chk({tag, "_data"}, wr_nonzero_data_o, 64'd0);
  endtask

  initial begin
    rst_i        = 1'b1;
    in_data_i    = '0;
    in_valid_i   = 1'b0;
    rd_release_i = 1'b0;
    step();
    step();
    chk_reset_vals("reset");

    rst_i = 1'b0;
    #1;
    chk("ready_after_reset", 64'(in_ready_o), 64'd1);

    // First chunk into bank 0: compression beat, all-zero beat, two more.
    in_valid_i = 1'b1;
    in_data_i  = BEAT_A;
    step();
    chk("beatA_valid", 64'(wr_valid_o), 64'd1);
    chk("beatA_map", 64'(wr_sparsemap_o), 64'(EXP_MAP_A));
    chk("beatA_data", wr_nonzero_data_o, EXP_DAT_A);
    chk("beatA_count", 64'(wr_count_o), 64'd0);
    chk("beatA_sel", 64'(wr_sel_o), 64'd0);
    in_data_i = 64'd0;
    step();
    chk("zero_valid", 64'(wr_valid_o), 64'd1);
    chk("zero_map", 64'(wr_sparsemap_o), 64'(EXP_MAP_Z));
    chk("zero_data", wr_nonzero_data_o, 64'd0);
    chk("zero_count", 64'(wr_count_o), 64'd1);
    in_data_i = 64'd1;
    step();
    chk("beat2_count", 64'(wr_count_o), 64'd2);
    step();
    chk("beat3_count", 64'(wr_count_o), 64'd3);
    chk("beat3_sel", 64'(wr_sel_o), 64'd0);
    chk("rdy_one_cycle_after", 64'(chunk_rdy_o), 64'd0);
    in_valid_i = 1'b0;
    step();
    chk("rdy_two_cycles_after", 64'(chunk_rdy_o), 64'd1);
    chk("rdy_rd_sel", 64'(rd_sel_o), 64'd0);
    chk("idle_no_strobe", 64'(wr_valid_o), 64'd0);

    // Second chunk goes to bank 1.
    in_valid_i = 1'b1;
    in_data_i  = BEAT_F;
    step();
    chk("bank1_first_sel", 64'(wr_sel_o), 64'd1);
    chk("bank1_first_count", 64'(wr_count_o), 64'd0);
    chk("full_lanes_map", 64'(wr_sparsemap_o), 64'hFF);
    chk("full_lanes_data", wr_nonzero_data_o, BEAT_F);
    step();
    step();
    chk("bank1_ready_mid", 64'(in_ready_o), 64'd1);
    step();
    chk("bank1_last_count", 64'(wr_count_o), 64'd3);
    chk("bank1_last_sel", 64'(wr_sel_o), 64'd1);
    chk("both_full_ready", 64'(in_ready_o), 64'd0);
    step();
    chk("stalled_no_strobe", 64'(wr_valid_o), 64'd0);
    step();
    chk("stalled_no_strobe2", 64'(wr_valid_o), 64'd0);
    chk("stalled_ready", 64'(in_ready_o), 64'd0);
    chk("stalled_rdy", 64'(chunk_rdy_o), 64'd1);

    // Release bank 0 while a beat is still offered.
    rd_release_i = 1'b1;
    step();
    rd_release_i = 1'b0;
    in_valid_i   = 1'b0;
    chk("rel0_rd_sel", 64'(rd_sel_o), 64'd1);
    chk("rel0_ready", 64'(in_ready_o), 64'd1);
    chk("rel0_rdy_bank1", 64'(chunk_rdy_o), 64'd1);
    chk("rel0_no_strobe", 64'(wr_valid_o), 64'd0);
    rd_release_i = 1'b1;
    step();
    rd_release_i = 1'b0;
    chk("rel1_rd_sel", 64'(rd_sel_o), 64'd0);
    chk("rel1_rdy", 64'(chunk_rdy_o), 64'd0);

    // Release with nothing ready must be ignored.
    rd_release_i = 1'b1;
    step();
    rd_release_i = 1'b0;
    chk("ignored_rel_rd_sel", 64'(rd_sel_o), 64'd0);
    chk("ignored_rel_rdy", 64'(chunk_rdy_o), 64'd0);

    // Reset after two beats of a chunk.
    in_valid_i = 1'b1;
    in_data_i  = BEAT_A;
    step();
    chk("pre_rst_count0", 64'(wr_count_o), 64'd0);
    step();
    chk("pre_rst_count1", 64'(wr_count_o), 64'd1);
    in_valid_i = 1'b0;
    rst_i      = 1'b1;
    step();
    chk_reset_vals("midrst");
    rst_i = 1'b0;
    #1;
    chk("midrst_ready_after", 64'(in_ready_o), 64'd1);

    // Eight back-to-back beats: two chunks without a bubble, then bank 0
    // is FULL again and the producer is stalled.
    in_valid_i = 1'b1;
    for (int i = 0; i < 8; i++) begin
      in_data_i = BEAT_F ^ 64'(i);
      step();
      chk($sformatf("stream%0d_valid", i), 64'(wr_valid_o), 64'd1);
      chk($sformatf("stream%0d_count", i), 64'(wr_count_o), 64'(i % 4));
      chk($sformatf("stream%0d_sel", i), 64'(wr_sel_o), 64'(i / 4));
      chk($sformatf("stream%0d_ready", i), 64'(in_ready_o), (i == 7) ? 64'd0 : 64'd1);
    end
    in_valid_i = 1'b0;
    step();
    chk("stream_end_rdy", 64'(chunk_rdy_o), 64'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
